vga_timing_gen: RTL and testbench

- Parametrised VGA raster generator; successor to the fixed 640x480, 1-bit-per-colour VGA output stage.
- Owns horizontal/vertical counters and generates hsync/vsync with configurable polarity.
- Exposes a one-cycle-ahead pixel request/coordinate interface to the upstream frame source, then registers the returned colour into aligned VGA outputs.
- Sits between the frame/pixel source and the board VGA pins; runs on the pixel clock.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_axis_counter.sv | 47 ++++
 rtl/vga_timing_gen.sv | 137 +++++++++++++
 tb/tb_vga_timing_gen.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: default 640x480@60 constants, a per-axis
// timing bundle and a ceil-log2 helper used to size the counters.
package vga_pkg;

   typedef struct packed {
      int unsigned sync;
      int unsigned bporch;
      int unsigned display;
      int unsigned fporch;
   } axis_timing_t;

   localparam int unsigned H_SYNCPULSE_DEF = 96;
   localparam int unsigned H_BPORCH_DEF    = 48;
   localparam int unsigned H_DISPLAY_DEF   = 640;
   localparam int unsigned H_FPORCH_DEF    = 16;
   localparam int unsigned V_SYNCPULSE_DEF = 2;
   localparam int unsigned V_BPORCH_DEF    = 33;
   localparam int unsigned V_DISPLAY_DEF   = 480;
   localparam int unsigned V_FPORCH_DEF    = 10;

   localparam axis_timing_t H_TIMING_DEF = '{
      sync: H_SYNCPULSE_DEF, bporch: H_BPORCH_DEF,
      display: H_DISPLAY_DEF, fporch: H_FPORCH_DEF};
   localparam axis_timing_t V_TIMING_DEF = '{
      sync: V_SYNCPULSE_DEF, bporch: V_BPORCH_DEF,
      display: V_DISPLAY_DEF, fporch: V_FPORCH_DEF};

   // Ceil-log2, never less than 1 so a width derived from it is always legal.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned w;
      w = 1;
      while ((64'd1 << w) < 64'(value)) w++;
      return w;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts sync, back porch, display, front porch and wraps.
// Used for both the horizontal (step = 1) and vertical (step = h wrap) axis.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter  int unsigned SYNC    = 96,
   parameter  int unsigned BPORCH  = 48,
   parameter  int unsigned DISPLAY = 640,
   parameter  int unsigned FPORCH  = 16,
   localparam int unsigned TOTAL   = SYNC + BPORCH + DISPLAY + FPORCH,
   localparam int unsigned CW      = clog2(TOTAL)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          step,
   output logic [CW-1:0] cnt,
   output logic          wrap,
   output logic          in_sync,
   output logic          in_display
);

   if (SYNC < 1 || BPORCH < 1 || DISPLAY < 1 || FPORCH < 1) begin : g_bad_timing
      $error("vga_axis_counter: every timing parameter must be >= 1");
   end

   localparam logic [CW-1:0] LAST      = CW'(TOTAL - 1);
   localparam logic [CW-1:0] DISP_LO   = CW'(SYNC + BPORCH);
   localparam logic [CW-1:0] DISP_HI   = CW'(SYNC + BPORCH + DISPLAY);
   localparam logic [CW-1:0] SYNC_END  = CW'(SYNC);

   // Region decode and wrap detect, all at full counter width.
   always_comb begin
      wrap       = step && (cnt == LAST);
      in_sync    = (cnt < SYNC_END);
      in_display = (cnt >= DISP_LO) && (cnt < DISP_HI);
   end

   // Position counter: advances on step, returns to 0 after the last position.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (step) begin
         cnt <= wrap ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator. Stage 0 presents a pixel request and
// coordinate one cycle ahead; stage 1 registers sync, de and colour so all
// pin outputs are mutually aligned.
// Optional macro VGA_TEST_PATTERN_EN adds input test_en, which replaces the
// incoming colour with 8 vertical bars.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter  int unsigned COLOR_W     = 1,
   parameter  int unsigned H_SYNCPULSE = H_SYNCPULSE_DEF,
   parameter  int unsigned H_BPORCH    = H_BPORCH_DEF,
   parameter  int unsigned H_DISPLAY   = H_DISPLAY_DEF,
   parameter  int unsigned H_FPORCH    = H_FPORCH_DEF,
   parameter  int unsigned V_SYNCPULSE = V_SYNCPULSE_DEF,
   parameter  int unsigned V_BPORCH    = V_BPORCH_DEF,
   parameter  int unsigned V_DISPLAY   = V_DISPLAY_DEF,
   parameter  int unsigned V_FPORCH    = V_FPORCH_DEF,
   parameter  int unsigned HSYNC_POL   = 0,
   parameter  int unsigned VSYNC_POL   = 0,
   localparam int unsigned H_TOTAL     = H_SYNCPULSE + H_BPORCH + H_DISPLAY + H_FPORCH,
   localparam int unsigned V_TOTAL     = V_SYNCPULSE + V_BPORCH + V_DISPLAY + V_FPORCH,
   localparam int unsigned XW          = clog2(H_DISPLAY),
   localparam int unsigned YW          = clog2(V_DISPLAY)
) (
   input  logic               clk,
   input  logic               rst,
`ifdef VGA_TEST_PATTERN_EN
   input  logic               test_en,
`endif
   input  logic [COLOR_W-1:0] rIn,
   input  logic [COLOR_W-1:0] gIn,
   input  logic [COLOR_W-1:0] bIn,
   output logic               pix_req,
   output logic [XW-1:0]      pix_x,
   output logic [YW-1:0]      pix_y,
   output logic               frame_start,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic [COLOR_W-1:0] r,
   output logic [COLOR_W-1:0] g,
   output logic [COLOR_W-1:0] b
);

   localparam axis_timing_t H_T = '{
      sync: H_SYNCPULSE, bporch: H_BPORCH, display: H_DISPLAY, fporch: H_FPORCH};
   localparam axis_timing_t V_T = '{
      sync: V_SYNCPULSE, bporch: V_BPORCH, display: V_DISPLAY, fporch: V_FPORCH};

   localparam int unsigned HCW = clog2(H_TOTAL);
   localparam int unsigned VCW = clog2(V_TOTAL);
   localparam logic HS_ACT = 1'(HSYNC_POL);
   localparam logic VS_ACT = 1'(VSYNC_POL);

   logic [HCW-1:0]     h_cnt;
   logic [VCW-1:0]     v_cnt;
   logic               h_wrap, h_in_sync, h_in_display;
   logic               v_wrap_unused, v_in_sync, v_in_display;
   logic [COLOR_W-1:0] r_nxt, g_nxt, b_nxt;

   vga_axis_counter #(
      .SYNC(H_T.sync), .BPORCH(H_T.bporch), .DISPLAY(H_T.display), .FPORCH(H_T.fporch)
   ) u_h_axis (
      .clk(clk), .rst(rst), .step(1'b1),
      .cnt(h_cnt), .wrap(h_wrap), .in_sync(h_in_sync), .in_display(h_in_display)
   );

   vga_axis_counter #(
      .SYNC(V_T.sync), .BPORCH(V_T.bporch), .DISPLAY(V_T.display), .FPORCH(V_T.fporch)
   ) u_v_axis (
      .clk(clk), .rst(rst), .step(h_wrap),
      .cnt(v_cnt), .wrap(v_wrap_unused), .in_sync(v_in_sync), .in_display(v_in_display)
   );

   // Stage 0: request and coordinates straight from the counters.
   always_comb begin
      pix_req     = h_in_display && v_in_display;
      pix_x       = pix_req ? XW'(h_cnt - HCW'(H_SYNCPULSE + H_BPORCH)) : '0;
      pix_y       = pix_req ? YW'(v_cnt - VCW'(V_SYNCPULSE + V_BPORCH)) : '0;
      frame_start = (h_cnt == '0) && (v_cnt == '0);
   end

`ifdef VGA_TEST_PATTERN_EN
   logic [2:0] bar;
   localparam bit H_POW2 = ((H_DISPLAY & (H_DISPLAY - 1)) == 0) && (H_DISPLAY >= 8);
   if (H_POW2) begin : g_bar_bits
      assign bar = pix_x[XW-1 -: 3];
   end else begin : g_bar_cmp
      // Bar k starts where pix_x * 8 first reaches k * H_DISPLAY.
      always_comb begin
         bar = '0;
         for (int unsigned k = 1; k < 8; k++) begin
            if (32'(pix_x) * 8 >= k * H_DISPLAY) bar = 3'(k);
         end
      end
   end
`endif

   // Colour for the next registered cycle: blanked outside the visible area.
   always_comb begin
      r_nxt = '0;
      g_nxt = '0;
      b_nxt = '0;
      if (pix_req) begin
         r_nxt = rIn;
         g_nxt = gIn;
         b_nxt = bIn;
`ifdef VGA_TEST_PATTERN_EN
         if (test_en) begin
            r_nxt = {COLOR_W{bar[2]}};
            g_nxt = {COLOR_W{bar[1]}};
            b_nxt = {COLOR_W{bar[0]}};
         end
`endif
      end
   end

   // Stage 1: aligned sync, display enable and colour to the pins.
   always_ff @(posedge clk) begin
      if (rst) begin
         hsync <= ~HS_ACT;
         vsync <= ~VS_ACT;
         de    <= 1'b0;
         r     <= '0;
         g     <= '0;
         b     <= '0;
      end else begin
         hsync <= h_in_sync ? HS_ACT : ~HS_ACT;
         vsync <= v_in_sync ? VS_ACT : ~VS_ACT;
         de    <= pix_req;
         r     <= r_nxt;
         g     <= g_nxt;
         b     <= b_nxt;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen on a small raster. The reference model
// tracks the flat position within a frame and derives every output from it.
module tb_vga_timing_gen;

   localparam int unsigned CW  = 2;
   localparam int unsigned HS  = 6,  HB = 5, HD = 16, HF = 3;
   localparam int unsigned VS  = 2,  VB = 3, VD = 6,  VF = 2;
   localparam int unsigned HT  = HS + HB + HD + HF;
   localparam int unsigned VT  = VS + VB + VD + VF;
   localparam int unsigned FT  = HT * VT;
   localparam int unsigned HSP = 1, VSP = 0;
   localparam int unsigned XW  = 4, YW = 3;
   localparam int unsigned NCYC = 5000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CW-1:0] rIn = '0, gIn = '0, bIn = '0;
   logic          pix_req, frame_start, hsync, vsync, de;
   logic [XW-1:0] pix_x;
   logic [YW-1:0] pix_y;
   logic [CW-1:0] r, g, b;
`ifdef VGA_TEST_PATTERN_EN
   logic          test_en = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .COLOR_W(CW),
      .H_SYNCPULSE(HS), .H_BPORCH(HB), .H_DISPLAY(HD), .H_FPORCH(HF),
      .V_SYNCPULSE(VS), .V_BPORCH(VB), .V_DISPLAY(VD), .V_FPORCH(VF),
      .HSYNC_POL(HSP), .VSYNC_POL(VSP)
   ) dut (
      .clk(clk), .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
      .test_en(test_en),
`endif
      .rIn(rIn), .gIn(gIn), .bIn(bIn),
      .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
      .hsync(hsync), .vsync(vsync), .de(de), .r(r), .g(g), .b(b)
   );

   task automatic check_equal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   initial begin
      int unsigned   pos;
      int unsigned   h, v, bar, rst_left, de_cnt;
      bit            vis, te, clean, mid_done;
      logic          e_hs, e_vs, e_de;
      logic [CW-1:0] e_r, e_g, e_b;
      logic          hs_act, vs_act;

      hs_act   = 1'(HSP);
      vs_act   = 1'(VSP);
      rst_left = 0;
      de_cnt   = 0;
      clean    = 1'b0;
      mid_done = 1'b0;
      te       = 1'b0;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      pos  = 0;
      e_hs = ~hs_act; e_vs = ~vs_act; e_de = 1'b0;
      e_r  = '0; e_g = '0; e_b = '0;

      for (int unsigned n = 0; n < NCYC; n++) begin
         @(negedge clk);
         h   = pos % HT;
         v   = pos / HT;
         vis = (h >= HS + HB) && (h < HS + HB + HD) && (v >= VS + VB) && (v < VS + VB + VD);

         check_equal("pix_req", 32'(pix_req), 32'(vis));
         check_equal("pix_x", 32'(pix_x), vis ? h - (HS + HB) : 0);
         check_equal("pix_y", 32'(pix_y), vis ? v - (VS + VB) : 0);
         check_equal("frame_start", 32'(frame_start), 32'(pos == 0));
         check_equal("hsync", 32'(hsync), 32'(e_hs));
         check_equal("vsync", 32'(vsync), 32'(e_vs));
         check_equal("de", 32'(de), 32'(e_de));
         check_equal("r", 32'(r), 32'(e_r));
         check_equal("g", 32'(g), 32'(e_g));
         check_equal("b", 32'(b), 32'(e_b));

         // Whole uninterrupted frames must carry exactly HD*VD de-high cycles.
         if (frame_start === 1'b1) begin
            if (clean) check_equal("de_per_frame", de_cnt, HD * VD);
            de_cnt = 0;
            clean  = 1'b1;
         end
         if (de === 1'b1) de_cnt++;

         // Stimulus: one directed mid-frame reset plus occasional random ones.
         if (rst_left == 0) begin
            if (!mid_done && n > FT && pos == 8 * HT + 20) begin
               rst_left = 3;
               mid_done = 1'b1;
            end else if ($urandom_range(0, 1499) == 0) begin
               rst_left = $urandom_range(1, 4);
            end
         end
         rst = (rst_left != 0);
         if (rst_left != 0) begin
            rst_left--;
            clean = 1'b0;
         end
         rIn = CW'($urandom);
         gIn = CW'($urandom);
         bIn = CW'($urandom);
`ifdef VGA_TEST_PATTERN_EN
         if ($urandom_range(0, 199) == 0) test_en = ~test_en;
         te = test_en;
`endif

         // Model of the coming clock edge.
         if (rst) begin
            e_hs = ~hs_act; e_vs = ~vs_act; e_de = 1'b0;
            e_r  = '0; e_g = '0; e_b = '0;
            pos  = 0;
         end else begin
            e_hs = (h < HS) ? hs_act : ~hs_act;
            e_vs = (v < VS) ? vs_act : ~vs_act;
            e_de = vis;
            if (!vis) begin
               e_r = '0; e_g = '0; e_b = '0;
            end else if (te) begin
               bar = (h - (HS + HB)) * 8 / HD;
               e_r = {CW{bar[2]}};
               e_g = {CW{bar[1]}};
               e_b = {CW{bar[0]}};
            end else begin
               e_r = rIn; e_g = gIn; e_b = bIn;
            end
            pos = (pos + 1) % FT;
         end
      end

      check_equal("mid_frame_reset_hit", 32'(mid_done), 32'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
